hamming_decoder_secded: RTL and testbench
=========================================

Name: hamming_decoder_secded

Overview:
- Pipelined SECDED decoder for the team's 15+1 Hamming codewords (11 data bits, 4 Hamming parity bits, 1 overall parity bit).
- Sits on the read side of codeword storage or the link. Recovers the 11-bit data word, corrects any single-bit error, and flags double-bit errors.
- Valid/ready streaming at both ends. Two-stage pipeline. Saturating error-event counters for health monitoring.

Parameters:
- OVERALL_EN, 1: 1 = use bit 0 as the overall even-parity bit (SECDED). 0 = ignore bit 0 (SEC only, err_double never asserts).
- CNT_W, 16: width of each saturating error counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cw_in  in  16  codeword; bit index = Hamming position.
- in_valid  in  1  cw_in is valid.
- in_ready  out  1  decoder accepts cw_in this cycle.
- data_out  out  11  decoded data {d10..d0}.
- err_single  out  1  single-bit error detected and corrected.
- err_double  out  1  uncorrectable double-bit error.
- err_pos  out  4  corrected bit position (0 = none, or bit 0).
- out_valid  out  1  outputs valid.
- out_ready  in  1  downstream accepts the output.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of corrected words.
- uncorr_cnt  out  CNT_W  count of double-error words.

Behaviour:
- Codeword layout:
  - Parity bits p0..p3 sit at bits 1, 2, 4, 8.
  - Data bits: d0 = bit 3, d1..d3 = bits 5..7, d4..d10 = bits 9..15.
  - Bit 0 = XOR of bits 15:1 (overall even parity).
- Stage 1 (S1), on accept (in_valid && in_ready):
  - Register cw_in.
  - syndrome[3:0] = XOR of the indices of all set bits in cw_in[15:1].
  - pchk = XOR of cw_in[15:0].
- Stage 2 (S2) classification, OVERALL_EN=1:
  - syn==0, pchk==0: clean.
  - syn==0, pchk==1: single error at bit 0; err_single=1, err_pos=0, data unaffected.
  - syn!=0, pchk==1: single error; flip bit syn, err_single=1, err_pos=syn.
  - syn!=0, pchk==0: double error; err_double=1, err_pos=0, data_out = uncorrected extraction.
- Stage 2 classification, OVERALL_EN=0:
  - syn!=0: correct bit syn, err_single=1.
  - Otherwise clean; err_double is tied to 0.
- Latency: 2 cycles from accept to out_valid when there is no backpressure. Throughput: 1 word per cycle.
- Handshake:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = !s1_valid || S2 advances. The combinational out_ready -> in_ready path is permitted.
  - While out_valid && !out_ready, all outputs hold stable.
  - No bubbles are inserted. Full occupancy is 2 words.
- Counters:
  - Increment on output transfer (out_valid && out_ready): corr_cnt on err_single, uncorr_cnt on err_double.
  - Both saturate at 2^CNT_W-1; no wrap.
  - If cnt_clr coincides with an increment, the clear wins: result is 0 and the event is dropped.
- Reset:
  - Asserting rst_n low at any time, including mid-stream, clears s1_valid, s2_valid, out_valid, data_out, err_single, err_double, err_pos, corr_cnt and uncorr_cnt to 0 immediately.
  - in_ready reads 1 during and after reset.
  - In-flight words are discarded.
- Flags and err_pos are meaningful only while out_valid=1 but are registered; they are zeroed only by reset.

Test Plan:
- Clean word: cw_in=16'hB41E, out_ready=1 -> 2 cycles later data_out=11'h5A1, err_single=0, err_double=0, err_pos=0; counters unchanged.
- Single error: cw_in=16'hB45E (bit 6 flipped) -> data_out=11'h5A1, err_single=1, err_pos=6, corr_cnt +1. Also cw_in=16'hB41F (bit 0) -> data_out=11'h5A1, err_single=1, err_pos=0.
- Double error: cw_in=16'hB65E (bits 6, 9 flipped) -> err_double=1, data_out=11'h5B5 (uncorrected), uncorr_cnt +1. With OVERALL_EN=0, the same input gives err_single=1, err_pos=15.
- Backpressure:
  - Stream 16'h0000, 16'hB41E, 16'hB45E back-to-back with out_ready=0 -> in_ready drops after 2 accepts; outputs hold 11'h000.
  - Release out_ready -> outputs 11'h000, 11'h5A1, 11'h5A1 in order; none lost or duplicated.
- Counters with CNT_W=2: send 5 single-error words -> corr_cnt saturates at 3. Assert cnt_clr on the same cycle as a 6th transfer -> corr_cnt=0.
- Reset mid-stream: drop rst_n with 2 words in flight -> out_valid=0, counters=0, in_ready=1. After release, a new 16'hB41E decodes to 11'h5A1 with latency 2.

Source files
------------

// File: rtl/hamming_decoder_secded.sv
// hamming_decoder_secded
//   Two-stage pipelined SECDED decoder for 16-bit Hamming codewords
//   (11 data bits, parity bits at positions 1/2/4/8, overall even parity
//   at bit 0). It returns the data word with any single-bit error
//   corrected and flags words that carry a double-bit error. Two
//   saturating counters record corrected and uncorrectable words.
//
// Parameters:
//   OVERALL_EN  1 = bit 0 is the overall parity bit (SECDED);
//               0 = bit 0 is ignored (SEC only, err_double stays 0)
//   CNT_W       width of each saturating error counter
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cw_in, in_valid        input codeword and its valid
//   in_ready               decoder accepts cw_in this cycle
//   data_out               decoded data {d10..d0}
//   err_single, err_double error classification of the output word
//   err_pos                corrected bit position (0 = none or bit 0)
//   out_valid, out_ready   output handshake
//   cnt_clr                synchronous clear of both counters
//   corr_cnt, uncorr_cnt   corrected / double-error word counts
//
// Handshake: a word moves across an interface on every rising edge where
// valid && ready are both high. The output stage (S2) advances when it is
// empty or its word is taken (!s2Valid || out_ready); the input stage (S1)
// advances when it is empty or S2 advances, and in_ready is exactly that
// condition, so out_ready reaches in_ready combinationally. A stalled
// output holds every output stable. The pipeline holds at most two words.
module hamming_decoder_secded #(
    parameter int OVERALL_EN = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      cw_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [10:0]      data_out,
    output logic             err_single,
    output logic             err_double,
    output logic [3:0]       err_pos,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // XOR of the indices of all set bits in positions 15..1. For a valid
    // codeword this is zero; for a single flipped bit it is that bit's index.
    function automatic logic [3:0] calcSyndrome(input logic [15:0] cw);
        logic [3:0] syn;
        syn = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (cw[i]) begin
                syn = syn ^ i[3:0];
            end
        end
        return syn;
    endfunction

    function automatic logic [10:0] extractData(input logic [15:0] cw);
        return {cw[15:9], cw[7:5], cw[3]};
    endfunction

    // Stage 1 registers
    logic        s1Valid;
    logic [15:0] s1Cw;
    logic [3:0]  s1Syn;
    logic        s1Pchk;

    // Stage 2 valid; the stage 2 payload registers are the outputs
    logic        s2Valid;

    logic        s2Adv;
    logic        xfer;

    // Next stage 2 payload, classified from the stage 1 registers
    logic [15:0] corrCw;
    logic [10:0] nextData;
    logic        nextSingle;
    logic        nextDouble;
    logic [3:0]  nextPos;

    assign s2Adv     = !s2Valid || out_ready;
    assign in_ready  = !s1Valid || s2Adv;
    assign out_valid = s2Valid;
    assign xfer      = s2Valid && out_ready;

    always_comb begin
        corrCw     = s1Cw;
        nextSingle = 1'b0;
        nextDouble = 1'b0;
        nextPos    = 4'd0;
        if (OVERALL_EN != 0) begin
            if (s1Pchk) begin
                // Odd overall parity: exactly one bit flipped. A zero
                // syndrome points at bit 0, which carries no data.
                nextSingle = 1'b1;
                nextPos    = s1Syn;
                corrCw     = s1Cw ^ (16'd1 << s1Syn);
            end else if (s1Syn != 4'd0) begin
                // Even parity but nonzero syndrome: two bits flipped,
                // data is passed through uncorrected.
                nextDouble = 1'b1;
            end
        end else if (s1Syn != 4'd0) begin
            nextSingle = 1'b1;
            nextPos    = s1Syn;
            corrCw     = s1Cw ^ (16'd1 << s1Syn);
        end
        nextData = extractData(corrCw);
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid    <= 1'b0;
            s1Cw       <= 16'd0;
            s1Syn      <= 4'd0;
            s1Pchk     <= 1'b0;
            s2Valid    <= 1'b0;
            data_out   <= 11'd0;
            err_single <= 1'b0;
            err_double <= 1'b0;
            err_pos    <= 4'd0;
        end else begin
            if (in_ready) begin
                s1Valid <= in_valid;
                if (in_valid) begin
                    s1Cw   <= cw_in;
                    s1Syn  <= calcSyndrome(cw_in);
                    s1Pchk <= ^cw_in;
                end
            end
            if (s2Adv) begin
                s2Valid <= s1Valid;
                // Payload only loads with a real word so flags stay put
                // while the output stage sits empty.
                if (s1Valid) begin
                    data_out   <= nextData;
                    err_single <= nextSingle;
                    err_double <= nextDouble;
                    err_pos    <= nextPos;
                end
            end
        end
    end

    // Saturating error counters; a clear in the same cycle as an event wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (xfer) begin
            if (err_single && (corr_cnt != CNT_MAX)) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
            if (err_double && (uncorr_cnt != CNT_MAX)) begin
                uncorr_cnt <= uncorr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_decoder_secded.sv
// tb_hamming_decoder_secded
//   Drives two decoder instances from the same input stream: dutA is the
//   SECDED build with 16-bit counters, dutB the SEC-only build with 2-bit
//   counters. Expected outputs come from a nearest-codeword reference that
//   re-encodes candidate data and searches single-bit flips.
module tb_hamming_decoder_secded;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [15:0] cwIn = 16'd0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;
    logic        cntClr = 1'b0;

    logic        inReady, inReadyB;
    logic [10:0] dataA, dataB;
    logic        singleA, singleB, doubleA, doubleB;
    logic [3:0]  posA, posB;
    logic        validA, validB;
    logic [15:0] corrA, uncorrA;
    logic [1:0]  corrB, uncorrB;

    int nChecks = 0;
    int nFails  = 0;

    logic [16:0] expAQ[$];
    logic [16:0] expBQ[$];
    int modelCorrA = 0, modelUncorrA = 0, modelCorrB = 0, modelUncorrB = 0;

    always #5 clk = ~clk;

    hamming_decoder_secded #(.OVERALL_EN(1), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rstN), .cw_in(cwIn), .in_valid(inValid),
        .in_ready(inReady), .data_out(dataA), .err_single(singleA),
        .err_double(doubleA), .err_pos(posA), .out_valid(validA),
        .out_ready(outReady), .cnt_clr(cntClr), .corr_cnt(corrA),
        .uncorr_cnt(uncorrA)
    );

    hamming_decoder_secded #(.OVERALL_EN(0), .CNT_W(2)) dutB (
        .clk(clk), .rst_n(rstN), .cw_in(cwIn), .in_valid(inValid),
        .in_ready(inReadyB), .data_out(dataB), .err_single(singleB),
        .err_double(doubleB), .err_pos(posB), .out_valid(validB),
        .out_ready(outReady), .cnt_clr(cntClr), .corr_cnt(corrB),
        .uncorr_cnt(uncorrB)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int posOf(input int j);
        if (j == 0) return 3;
        else if (j < 4) return j + 4;
        else return j + 5;
    endfunction

    function automatic logic [10:0] refExtract(input logic [15:0] cw);
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = cw[posOf(j)];
        return d;
    endfunction

    function automatic logic [15:0] refEncode(input logic [10:0] d);
        logic [15:0] cw;
        logic p;
        cw = 16'd0;
        for (int j = 0; j < 11; j++) cw[posOf(j)] = d[j];
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int i = 1; i < 16; i++) begin
                if (((i >> k) & 1) == 1 && i != (1 << k)) p = p ^ cw[i];
            end
            cw[1 << k] = p;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic bit refIsCodeword(input logic [15:0] cw, input bit oe);
        logic [15:0] e;
        e = refEncode(refExtract(cw));
        if (oe) return e == cw;
        return e[15:1] == cw[15:1];
    endfunction

    // {data[10:0], single, double, pos[3:0]}
    function automatic logic [16:0] refDecode(input logic [15:0] cw, input bit oe);
        logic [16:0] r;
        logic [15:0] f;
        bit found;
        logic [3:0] p4;
        found = 1'b0;
        r = {refExtract(cw), 6'b0};
        if (!refIsCodeword(cw, oe)) begin
            for (int i = 0; i < 16; i++) begin
                if (!found && (oe || i != 0)) begin
                    f = cw ^ (16'd1 << i);
                    if (refIsCodeword(f, oe)) begin
                        found = 1'b1;
                        p4 = i[3:0];
                        r = {refExtract(f), 1'b1, 1'b0, p4};
                    end
                end
            end
            if (!found) r = {refExtract(cw), 1'b0, 1'b1, 4'd0};
        end
        return r;
    endfunction

    function automatic logic [15:0] genWord();
        logic [15:0] cw;
        int nErr;
        if ($urandom_range(0, 7) == 0) return 16'($urandom);
        cw = refEncode(11'($urandom_range(0, 2047)));
        nErr = $urandom_range(0, 3);
        for (int e = 0; e < nErr; e++) cw[$urandom_range(0, 15)] ^= 1'b1;
        return cw;
    endfunction

    function automatic int satInc(input int v, input int maxV);
        return (v < maxV) ? v + 1 : v;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [16:0] e;
        if (rstN) begin
            checkEq("corr_cnt_A", corrA, modelCorrA);
            checkEq("uncorr_cnt_A", uncorrA, modelUncorrA);
            checkEq("corr_cnt_B", corrB, modelCorrB);
            checkEq("uncorr_cnt_B", uncorrB, modelUncorrB);
            if (validA && outReady) begin
                e = (expAQ.size() > 0) ? expAQ.pop_front() : 17'h1FFFF;
                checkEq("out_A", {dataA, singleA, doubleA, posA}, e);
            end
            if (validB && outReady) begin
                e = (expBQ.size() > 0) ? expBQ.pop_front() : 17'h1FFFF;
                checkEq("out_B", {dataB, singleB, doubleB, posB}, e);
            end
            if (cntClr) begin
                modelCorrA = 0; modelUncorrA = 0; modelCorrB = 0; modelUncorrB = 0;
            end else begin
                if (validA && outReady && singleA) modelCorrA = satInc(modelCorrA, 65535);
                if (validA && outReady && doubleA) modelUncorrA = satInc(modelUncorrA, 65535);
                if (validB && outReady && singleB) modelCorrB = satInc(modelCorrB, 3);
                if (validB && outReady && doubleB) modelUncorrB = satInc(modelUncorrB, 3);
            end
            if (inValid && inReady) begin
                expAQ.push_back(refDecode(cwIn, 1'b1));
                expBQ.push_back(refDecode(cwIn, 1'b0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic flushModel();
        expAQ.delete();
        expBQ.delete();
        modelCorrA = 0; modelUncorrA = 0; modelCorrB = 0; modelUncorrB = 0;
    endtask

    // Sends one word with out_ready high; returns at the negedge where
    // out_valid is first seen, with the number of rising edges since accept.
    task automatic sendAndCatch(input logic [15:0] cw, output int lat);
        int guard;
        @(posedge clk); #1;
        cwIn = cw; inValid = 1'b1; outReady = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!inReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        inValid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!validA && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pulseClear();
        @(posedge clk); #1; cntClr = 1'b1;
        @(posedge clk); #1; cntClr = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    logic [15:0] bpWords[3];
    logic [10:0] got[3];
    int lat, sendIdx, gotCnt, guard;
    bit lastAccepted;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bpWords[0] = 16'h0000; bpWords[1] = 16'hB41E; bpWords[2] = 16'hB45E;

        // reset state
        #12;
        checkEq("rst_valid_A", validA, 0);
        checkEq("rst_in_ready", inReady, 1);
        checkEq("rst_data_A", dataA, 0);
        checkEq("rst_flags_A", {singleA, doubleA, posA}, 0);
        checkEq("rst_cnt_A", {corrA, uncorrA}, 0);
        checkEq("rst_cnt_B", {corrB, uncorrB}, 0);
        @(posedge clk); #3; rstN = 1'b1;

        // directed decodes
        sendAndCatch(16'hB41E, lat);
        checkEq("clean_lat", lat, 2);
        checkEq("clean_data_A", dataA, 11'h5A1);
        checkEq("clean_flags_A", {singleA, doubleA, posA}, 0);
        checkEq("clean_data_B", dataB, 11'h5A1);

        sendAndCatch(16'hB45E, lat);
        checkEq("single6_lat", lat, 2);
        checkEq("single6_A", {dataA, singleA, doubleA, posA}, {11'h5A1, 1'b1, 1'b0, 4'd6});
        checkEq("single6_B", {dataB, singleB, doubleB, posB}, {11'h5A1, 1'b1, 1'b0, 4'd6});
        checkEq("clean_no_count", corrA, 0);

        sendAndCatch(16'hB41F, lat);
        checkEq("single0_A", {dataA, singleA, doubleA, posA}, {11'h5A1, 1'b1, 1'b0, 4'd0});
        checkEq("single0_B_ignored", {dataB, singleB, doubleB, posB}, {11'h5A1, 1'b0, 1'b0, 4'd0});
        checkEq("single6_count_A", corrA, 1);

        sendAndCatch(16'hB65E, lat);
        checkEq("double_A", {dataA, singleA, doubleA, posA}, {11'h5B5, 1'b0, 1'b1, 4'd0});
        checkEq("double_B_sec", {dataB, singleB, doubleB, posB}, {11'h1B5, 1'b1, 1'b0, 4'd15});
        @(posedge clk); #1;
        checkEq("dir_corr_A", corrA, 2);
        checkEq("dir_uncorr_A", uncorrA, 1);
        checkEq("dir_corr_B", corrB, 2);
        checkEq("dir_uncorr_B", uncorrB, 0);

        // backpressure: two accepts then stall
        sendIdx = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            outReady = 1'b0;
            inValid = (sendIdx < 3);
            if (sendIdx < 3) cwIn = bpWords[sendIdx];
            @(negedge clk);
            if (validA) checkEq("bp_hold_data", dataA, 11'h000);
            if (inValid && inReady) sendIdx++;
        end
        checkEq("bp_accepts", sendIdx, 2);
        checkEq("bp_in_ready", inReady, 0);
        checkEq("bp_out_valid", validA, 1);
        gotCnt = 0; guard = 0;
        while (gotCnt < 3 && guard < 20) begin
            @(posedge clk); #1;
            outReady = 1'b1;
            inValid = (sendIdx < 3);
            if (sendIdx < 3) cwIn = bpWords[sendIdx];
            @(negedge clk);
            if (validA) begin
                got[gotCnt] = dataA;
                gotCnt++;
            end
            if (inValid && inReady) sendIdx++;
            guard++;
        end
        checkEq("bp_out_count", gotCnt, 3);
        checkEq("bp_out0", got[0], 11'h000);
        checkEq("bp_out1", got[1], 11'h5A1);
        checkEq("bp_out2", got[2], 11'h5A1);
        @(posedge clk); #1; inValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkEq("bp_no_dup", validA, 0);

        // counter saturation on the 2-bit instance, clear beats increment
        pulseClear();
        sendIdx = 0; guard = 0;
        while (sendIdx < 5 && guard < 30) begin
            @(posedge clk); #1;
            inValid = 1'b1; cwIn = 16'hB45E; outReady = 1'b1;
            @(negedge clk);
            if (inReady) sendIdx++;
            guard++;
        end
        @(posedge clk); #1; inValid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkEq("sat_corr_B", corrB, 3);
        checkEq("sat_corr_A", corrA, 5);
        @(posedge clk); #1;
        inValid = 1'b1; cwIn = 16'hB45E;
        @(posedge clk); #1;
        inValid = 1'b0;
        guard = 0;
        while (!validA && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        cntClr = 1'b1;
        @(posedge clk); #1;
        cntClr = 1'b0;
        checkEq("clr_wins_A", corrA, 0);
        checkEq("clr_wins_B", corrB, 0);

        // randomized traffic with random stalls and clears
        lastAccepted = 1'b0;
        inValid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (!inValid || lastAccepted) begin
                inValid = ($urandom_range(0, 9) < 7);
                cwIn = genWord();
            end
            outReady = ($urandom_range(0, 9) < 6);
            cntClr = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            lastAccepted = inValid && inReady;
        end
        @(posedge clk); #1;
        inValid = 1'b0; outReady = 1'b1; cntClr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkEq("drain_A", expAQ.size(), 0);
        checkEq("drain_B", expBQ.size(), 0);

        // reset with two words in flight
        outReady = 1'b0;
        sendIdx = 0; guard = 0;
        while (sendIdx < 2 && guard < 10) begin
            @(posedge clk); #1;
            inValid = 1'b1; cwIn = 16'hB45E;
            @(negedge clk);
            if (inReady) sendIdx++;
            guard++;
        end
        @(posedge clk); #3;
        inValid = 1'b0;
        rstN = 1'b0;
        #1;
        checkEq("mid_rst_valid", validA, 0);
        checkEq("mid_rst_in_ready", inReady, 1);
        checkEq("mid_rst_flags", {dataA, singleA, doubleA, posA}, 0);
        checkEq("mid_rst_cnt_A", {corrA, uncorrA}, 0);
        checkEq("mid_rst_cnt_B", {corrB, uncorrB}, 0);
        flushModel();
        #10;
        rstN = 1'b1;
        sendAndCatch(16'hB41E, lat);
        checkEq("post_rst_lat", lat, 2);
        checkEq("post_rst_data", dataA, 11'h5A1);
        @(posedge clk); #1;
        outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkEq("post_rst_empty", validA, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
